// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with registered read data, one-cycle
// handshake/error pulses and programmable almost-full/almost-empty levels.
//
// State table (state_q holds the operation decided at the last edge):
//   state       | meaning
//   ST_INIT     | just reset, no operation performed yet
//   ST_NO_OP    | no request last cycle
//   ST_WRITE    | write accepted (read also rejected if coll_q)
//   ST_WR_ERROR | write-only request rejected, FIFO was full
//   ST_READ     | read accepted (write also rejected if coll_q)
//   ST_RD_ERROR | read-only request rejected, FIFO was empty
//   ST_RW       | simultaneous write and read both accepted
//
// Ports:
//   clk_i            clock, all state changes on rising edge
//   reset_i          synchronous active-high reset
//   wr_en_i, din_i   write request and data
//   rd_en_i          read request
//   dout_o           registered read data, held until next accepted read
//   full_o, empty_o, almost_full_o, almost_empty_o   status from count
//   wr_ack_o, wr_err_o, rd_ack_o, rd_err_o           one-cycle pulses
//   data_count_o     number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  wr_ack_o,
    output logic                  wr_err_o,
    output logic                  rd_ack_o,
    output logic                  rd_err_o,
    output logic [ADDR_WIDTH:0]   data_count_o
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_NO_OP,
        ST_WRITE,
        ST_WR_ERROR,
        ST_READ,
        ST_RD_ERROR,
        ST_RW
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AE_CNT    = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] head_q;
    logic [ADDR_WIDTH-1:0] tail_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [DATA_WIDTH-1:0] dout_q;
    state_t                state_q;
    state_t                state_d;
    // Set when both requests arrived at a boundary and one side was refused.
    logic                  coll_q;
    logic                  coll_d;
    logic                  do_wr;
    logic                  do_rd;
    logic                  is_full;
    logic                  is_empty;

    assign is_full  = (count_q == DEPTH_CNT);
    assign is_empty = (count_q == '0);

    always_comb begin
        state_d = ST_NO_OP;
        coll_d  = 1'b0;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        case ({wr_en_i, rd_en_i})
            2'b10: begin
                if (is_full) begin
                    state_d = ST_WR_ERROR;
                end else begin
                    state_d = ST_WRITE;
                    do_wr   = 1'b1;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    state_d = ST_RD_ERROR;
                end else begin
                    state_d = ST_READ;
                    do_rd   = 1'b1;
                end
            end
            2'b11: begin
                // No bypass at empty: the write lands, the read is refused.
                if (is_empty) begin
                    state_d = ST_WRITE;
                    do_wr   = 1'b1;
                    coll_d  = 1'b1;
                end else if (is_full) begin
                    state_d = ST_READ;
                    do_rd   = 1'b1;
                    coll_d  = 1'b1;
                end else begin
                    state_d = ST_RW;
                    do_wr   = 1'b1;
                    do_rd   = 1'b1;
                end
            end
            default: state_d = ST_NO_OP;
        endcase
    end

    // Storage has no reset; contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i && do_wr) begin
            mem_q[tail_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            state_q <= ST_INIT;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            coll_q  <= coll_d;
            if (do_wr) begin
                tail_q <= tail_q + PTR_ONE;
            end
            if (do_rd) begin
                dout_q <= mem_q[head_q];
                head_q <= head_q + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Pulses decode from registered state only, so they carry no input path.
    assign wr_ack_o = (state_q == ST_WRITE) || (state_q == ST_RW);
    assign rd_ack_o = (state_q == ST_READ)  || (state_q == ST_RW);
    assign wr_err_o = (state_q == ST_WR_ERROR) || ((state_q == ST_READ) && coll_q);
    assign rd_err_o = (state_q == ST_RD_ERROR) || ((state_q == ST_WRITE) && coll_q);

    assign dout_o         = dout_q;
    assign data_count_o   = count_q;
    assign full_o         = is_full;
    assign empty_o        = is_empty;
    assign almost_full_o  = (count_q >= AF_CNT);
    assign almost_empty_o = (count_q <= AE_CNT);

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Bench for sync_fifo_param: directed sequences followed by random traffic,
// every cycle compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [DW-1:0] din_i = '0;
    logic          rd_en_i = 1'b0;
    logic [DW-1:0] dout_o;
    logic          full_o, empty_o, almost_full_o, almost_empty_o;
    logic          wr_ack_o, wr_err_o, rd_ack_o, rd_err_o;
    logic [AW:0]   data_count_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    // reference model state
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout = '0;
    logic          exp_wa, exp_we, exp_ra, exp_re;

    sync_fifo_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .wr_en_i(wr_en_i), .din_i(din_i),
        .rd_en_i(rd_en_i), .dout_o(dout_o), .full_o(full_o), .empty_o(empty_o),
        .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
        .wr_ack_o(wr_ack_o), .wr_err_o(wr_err_o), .rd_ack_o(rd_ack_o),
        .rd_err_o(rd_err_o), .data_count_o(data_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = model_q.size();
        check_val({ctx, ".count"},  64'(data_count_o), 64'(n));
        check_val({ctx, ".empty"},  64'(empty_o), 64'(n == 0));
        check_val({ctx, ".full"},   64'(full_o), 64'(n == DEPTH));
        check_val({ctx, ".afull"},  64'(almost_full_o), 64'(n >= AF));
        check_val({ctx, ".aempty"}, 64'(almost_empty_o), 64'(n <= AE));
        check_val({ctx, ".dout"},   64'(dout_o), 64'(exp_dout));
        check_val({ctx, ".wr_ack"}, 64'(wr_ack_o), 64'(exp_wa));
        check_val({ctx, ".wr_err"}, 64'(wr_err_o), 64'(exp_we));
        check_val({ctx, ".rd_ack"}, 64'(rd_ack_o), 64'(exp_ra));
        check_val({ctx, ".rd_err"}, 64'(rd_err_o), 64'(exp_re));
    endtask

    // One clock with the given requests; model updated from FIFO rules.
    task automatic step(input string ctx, input logic rst, input logic wr,
                        input logic rd, input logic [DW-1:0] d);
        logic can_w, can_r;
        reset_i = rst;
        wr_en_i = wr;
        rd_en_i = rd;
        din_i   = d;
        if (rst) begin
            model_q.delete();
            exp_dout = '0;
            exp_wa = 0; exp_we = 0; exp_ra = 0; exp_re = 0;
        end else begin
            can_w  = wr && (model_q.size() < DEPTH);
            can_r  = rd && (model_q.size() > 0);
            exp_wa = can_w;
            exp_we = wr && !can_w;
            exp_ra = can_r;
            exp_re = rd && !can_r;
            if (can_r) exp_dout = model_q.pop_front();
            if (can_w) model_q.push_back(d);
        end
        @(posedge clk_i);
        #1;
        check_all(ctx);
    endtask

    initial begin
        // 1: reset with both requests active
        step("rst", 1, 1, 1, 32'hDEAD);
        step("rst", 1, 1, 1, 32'hBEEF);
        step("idle", 0, 0, 0, '0);

        // 2: fill and overflow
        for (int i = 1; i <= 8; i++) step("fill", 0, 1, 0, DW'(i * 32'h11));
        step("ovf", 0, 1, 0, 32'h99);
        step("ovf_after", 0, 0, 0, '0);

        // 3: drain and underflow
        for (int i = 0; i < 8; i++) step("drain", 0, 0, 1, '0);
        step("udf", 0, 0, 1, '0);
        step("udf_after", 0, 0, 0, '0);

        // 4: wrap-around
        for (int i = 0; i < 5; i++) step("wrap_w5", 0, 1, 0, $urandom);
        for (int i = 0; i < 5; i++) step("wrap_r5", 0, 0, 1, '0);
        for (int i = 0; i < 8; i++) step("wrap_w8", 0, 1, 0, DW'(32'hA0 + i));
        for (int i = 0; i < 8; i++) step("wrap_r8", 0, 0, 1, '0);

        // 5: simultaneous requests
        for (int i = 0; i < 3; i++) step("sim_pre", 0, 1, 0, $urandom);
        for (int i = 0; i < 4; i++) step("sim_rw", 0, 1, 1, 32'hCC);
        for (int i = 0; i < 3; i++) step("sim_drain", 0, 0, 1, '0);
        step("sim_empty", 0, 1, 1, 32'h5A);
        for (int i = 0; i < 7; i++) step("sim_fill", 0, 1, 0, $urandom);
        step("sim_full", 0, 1, 1, 32'hA5);

        // 6: thresholds and mid-operation reset
        for (int i = 0; i < 7; i++) step("thr_drain", 0, 0, 1, '0);
        for (int i = 0; i < 6; i++) step("thr_up", 0, 1, 0, $urandom);
        step("thr_down", 0, 0, 1, '0);
        step("mid_rst", 1, 1, 0, 32'h77);
        step("rst_rd", 0, 0, 1, '0);

        // random traffic, phases biased toward full and toward empty
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 100) % 2 == 0) ? 75 : 25;
            step("rand", ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < wp),
                 ($urandom_range(0, 99) < (100 - wp)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. It is the next generation of the fixed 8x32 register-file FIFO, with configurable width and depth, read/write handshake acknowledges, error flags and programmable almost-full/almost-empty thresholds. It sits between a single-clock producer and consumer and provides registered status outputs and a registered read-data output.

Parameters:
DATA_WIDTH, 32, width of each stored word
DEPTH, 8, number of entries; must be a power of 2 and at least 2
ADDR_WIDTH, 3, pointer width; must equal log2(DEPTH)
AF_LEVEL, 6, almost_full asserts when data_count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when data_count <= AE_LEVEL

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request
din  in  DATA_WIDTH  write data
rd_en  in  1  read request
dout  out  DATA_WIDTH  registered read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
wr_ack  out  1  one-cycle pulse: previous-cycle write accepted
wr_err  out  1  one-cycle pulse: previous-cycle write rejected (full)
rd_ack  out  1  one-cycle pulse: previous-cycle read accepted; dout valid
rd_err  out  1  one-cycle pulse: previous-cycle read rejected (empty)
data_count  out  ADDR_WIDTH+1  number of stored words, 0..DEPTH

Behaviour:
- Reset (clk edge with reset=1):
  - head, tail and count are set to 0.
  - dout=0; wr_ack, wr_err, rd_ack and rd_err are 0.
  - State is INIT; empty=1, full=0, almost_empty=1, almost_full=0 (with default parameters).
  - Memory contents are not cleared.
  - Reset overrides wr_en/rd_en in the same cycle, including mid-operation.
- State register (encoded next-state): INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR, RW.
  - The state is a function of the current-cycle requests and the current count, and is registered at the edge.
  - wr_en=0, rd_en=0 -> NO_OP.
  - Write only: WRITE if count<DEPTH, else WR_ERROR.
  - Read only: READ if count>0, else RD_ERROR.
  - Both, with 0<count<DEPTH -> RW: both accepted, count unchanged.
  - Both, with count==0 -> WRITE, and rd_err is also raised. No bypass: dout is unchanged.
  - Both, with count==DEPTH -> READ, and wr_err is also raised.
- Accepted write:
  - mem[tail] <= din.
  - tail <= tail+1, wrapping modulo DEPTH.
  - count increments (unless RW).
  - wr_ack=1 in the next cycle.
- Accepted read:
  - dout <= mem[head].
  - head <= head+1, wrapping modulo DEPTH.
  - count decrements (unless RW).
  - rd_ack=1 in the next cycle; dout holds the word from that cycle onward.
  - dout holds its value until the next accepted read.
- Rejected operations:
  - No pointer, count, memory or dout change.
  - The matching error pulse is 1 for exactly one cycle.
- Pulse outputs:
  - The ack/err pulses are registered and deassert in the following cycle unless re-triggered.
  - wr_ack and wr_err are never both 1; rd_ack and rd_err are never both 1.
- Status flags and data_count are decoded from the registered count. They reflect operations one cycle after the requesting edge.
- Latency:
  - A write is visible to a read issued in the cycle after wr_ack.
  - Read latency is 1 cycle, request to dout.
- Ordering is strict FIFO, including across pointer wrap-around.
- Out-of-range parameters (AF_LEVEL > DEPTH, AE_LEVEL >= DEPTH) are unsupported; the bench keeps them in range.

Test Plan:
1. Reset: assert reset 2 cycles with wr_en=rd_en=1 -> after release, empty=1, data_count=0, dout=0, all ack/err=0.
2. Fill and overflow: write 0x11..0x88 (8 writes) -> wr_ack each cycle, full=1 and almost_full=1 after 8th. A 9th write of 0x99 -> wr_err=1 for 1 cycle, data_count stays 8.
3. Drain and underflow: 8 reads -> dout=0x11..0x88 in order with rd_ack, empty=1 after. A 9th read -> rd_err=1, dout holds 0x88.
4. Wrap-around: write 5, read 5, write 8 (0xA0..0xA7), read 8 -> dout sequence 0xA0..0xA7, data_count returns to 0.
5. Simultaneous:
   - With count=3, wr_en=rd_en=1 with din=0xCC for 4 cycles -> count stays 3, rd_ack and wr_ack each cycle.
   - At count=0, both requests -> wr_ack=1, rd_err=1, count=1.
   - At count=8, both requests -> rd_ack=1, wr_err=1, count=7.
6. Thresholds and mid-operation reset:
   - Counts 2->3 -> almost_empty 1->0.
   - Counts 5->6 -> almost_full 0->1.
   - Reset at count=5 while wr_en=1 -> next cycle count=0, empty=1, no wr_ack.
   - A subsequent read -> rd_err=1.
